// File: rtl/fetch_buffer_pkg.sv
// rtl/fetch_buffer_pkg.sv - shared types and constants for the instruction fetch buffer
package fetch_buffer_pkg;

  localparam int FB_PC_W    = 9;
  localparam int FB_INS_W   = 32;
  localparam int FB_DEPTH   = 4;
  localparam int FB_MAX_OUT = 2;

  typedef struct packed {
    logic [FB_PC_W-1:0]  pc;
    logic [FB_INS_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - first-word-fall-through entry store with synchronous clear
module fetch_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - credit-limited instruction prefetch with redirect flush and stale-response drain
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int PC_W    = FB_PC_W,
  parameter int INS_W   = FB_INS_W,
  parameter int DEPTH   = FB_DEPTH,
  parameter int MAX_OUT = FB_MAX_OUT
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [INS_W-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             out_valid,
  output logic [PC_W-1:0]  out_pc,
  output logic [INS_W-1:0] out_instr,
  input  logic             out_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  fetch_state_t state, next_state;
  logic [PC_W-1:0]       fetch_pc, resp_pc;
  logic [OW-1:0]         outstanding, outstanding_next;
  logic [OW-1:0]         stale, stale_next;
  logic [CW-1:0]         count;
  logic [PC_W+INS_W-1:0] head;
  logic flush, grant, rsp, push, pop, credit_ok;

  assign flush            = redirect && (state != IDLE);
  assign grant            = imem_req && imem_gnt;
  // responses seen in IDLE belong to requests abandoned by reset
  assign rsp              = imem_rvalid && (state != IDLE) && (outstanding != '0);
  assign outstanding_next = outstanding + OW'(grant) - OW'(rsp);
  assign push             = rsp && !flush && (stale == '0);
  assign out_valid        = (count != '0);
  assign pop              = out_valid && out_ready && !redirect;
  assign credit_ok        = (outstanding < OW'(MAX_OUT)) &&
                            ((SW'(count) + SW'(outstanding)) < SW'(DEPTH));

  // stale is recomputed from scratch on every flush so a redirect in DRAIN never accumulates
  always_comb begin
    stale_next = stale;
    if (flush)                      stale_next = outstanding_next;
    else if (rsp && stale != '0)    stale_next = stale - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    next_state = FETCH;
      FETCH:   if (flush && stale_next != '0) next_state = DRAIN;
      DRAIN:   if (stale_next == '0) next_state = FETCH;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    if (state == FETCH && !redirect && credit_ok) imem_req = 1'b1;
  end

  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= '0;
      resp_pc     <= '0;
      outstanding <= '0;
      stale       <= '0;
    end else begin
      outstanding <= outstanding_next;
      stale       <= stale_next;
      if (flush) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
      end else begin
        if (grant) fetch_pc <= fetch_pc + PC_W'(4);
        if (push)  resp_pc  <= resp_pc + PC_W'(4);
      end
    end
  end

  fetch_fifo #(.W(PC_W + INS_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .din   ({resp_pc, imem_rdata}),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  assign out_pc    = out_valid ? head[PC_W+INS_W-1:INS_W] : '0;
  assign out_instr = out_valid ? head[INS_W-1:0]          : '0;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - directed self-checking bench for fetch_buffer
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic        out_valid;
  logic [8:0]  out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  logic        rsp_en;
  logic [8:0]  rq[$];
  logic [8:0]  glog[$];
  logic [8:0]  plog[$];
  logic [31:0] ilog[$];
  logic        s_req, s_valid, s_rvalid;
  logic [8:0]  s_addr, s_pc;
  logic [31:0] s_instr;

  always #5 clk = ~clk;

  fetch_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_ready   (out_ready)
  );

  function automatic logic [31:0] data_of(input logic [8:0] a);
    return 32'h5A00_0000 | {23'd0, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // one clock cycle, entered and left at a falling edge; memory answers in order one or more cycles after grant
  task automatic cyc();
    logic [8:0] a;
    if (rsp_en && rq.size() > 0) begin
      a = rq.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = data_of(a);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    s_req    = imem_req;
    s_addr   = imem_addr;
    s_valid  = out_valid;
    s_pc     = out_pc;
    s_instr  = out_instr;
    s_rvalid = imem_rvalid;
    if (imem_req && imem_gnt) begin
      rq.push_back(imem_addr);
      glog.push_back(imem_addr);
    end
    if (out_valid && out_ready && !redirect) begin
      plog.push_back(out_pc);
      ilog.push_back(out_instr);
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clear_logs();
    glog.delete();
    plog.delete();
    ilog.delete();
  endtask

  initial begin
    reset = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1; rsp_en = 1'b1;
    #3;
    check("rst_req",   32'(imem_req),  0);
    check("rst_addr",  32'(imem_addr), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_pc",    32'(out_pc),    0);
    check("rst_instr", out_instr,      0);
    @(negedge clk);
    reset = 1'b1;

    // streaming start
    cyc(); check("idle_req", 32'(s_req), 0);
    cyc(); check("req0", 32'(s_req), 1); check("addr0", 32'(s_addr), 0);
    cyc(); check("addr1", 32'(s_addr), 32'h4); check("lat_valid_n1", 32'(s_valid), 0);
    cyc(); check("addr2", 32'(s_addr), 32'h8); check("lat_valid_n2", 32'(s_valid), 1);
    check("lat_pc_n2", 32'(s_pc), 0); check("lat_instr_n2", s_instr, data_of(9'h0));

    // backpressure
    out_ready = 1'b0;
    run(10);
    check("bp_count", 32'(dut.count), 4);
    check("bp_req", 32'(s_req), 0);
    check("bp_head", 32'(s_pc), 32'h4);
    out_ready = 1'b1;
    run(8);
    check("bp_pops", 32'(plog.size() >= 6), 1);
    for (int i = 0; i < plog.size(); i++) begin
      check("bp_seq_pc", 32'(plog[i]), 32'(i * 4));
      check("bp_seq_instr", ilog[i], data_of(9'(i * 4)));
    end

    // redirect with two requests in flight
    imem_gnt = 1'b0;
    run(6);
    clear_logs();
    imem_gnt = 1'b1; rsp_en = 1'b0;
    run(2);
    redirect = 1'b1; redirect_pc = 9'h080;
    cyc();
    redirect = 1'b0;
    check("rd_granted", 32'(glog.size()), 2);
    check("rd_state", 32'(dut.state), 32'(DRAIN));
    rsp_en = 1'b1;
    cyc(); check("drain_req", 32'(s_req), 0); check("drain_state", 32'(dut.state), 32'(DRAIN));
    cyc();
    run(5);
    check("rd_fetch", 32'(glog.size() > 2 ? glog[2] : 9'h1ff), 32'h080);
    check("rd_out", 32'(plog.size() > 0 ? plog[0] : 9'h1ff), 32'h080);

    // redirect coinciding with a response and a pop
    clear_logs();
    redirect = 1'b1; redirect_pc = 9'h100;
    cyc();
    redirect = 1'b0;
    check("co_rvalid", 32'(s_rvalid), 1);
    check("co_valid_pre", 32'(s_valid), 1);
    cyc();
    check("co_valid_next", 32'(s_valid), 0);
    check("co_no_pop", 32'(plog.size()), 0);
    check("co_state", 32'(dut.state), 32'(FETCH));
    run(4);
    check("co_out", 32'(plog.size() > 0 ? plog[0] : 9'h1ff), 32'h100);

    // wrap-around
    clear_logs();
    redirect = 1'b1; redirect_pc = 9'h1FC;
    cyc();
    redirect = 1'b0;
    run(6);
    check("wr_cnt", 32'(glog.size() >= 3 && plog.size() >= 3), 1);
    check("wr_addr0", 32'(glog[0]), 32'h1FC);
    check("wr_addr1", 32'(glog[1]), 32'h000);
    check("wr_pc0",   32'(plog[0]), 32'h1FC);
    check("wr_pc1",   32'(plog[1]), 32'h000);
    check("wr_pc2",   32'(plog[2]), 32'h004);
    check("wr_instr1", ilog[1], data_of(9'h000));

    // reset with one request in flight
    imem_gnt = 1'b0;
    run(6);
    out_ready = 1'b0; imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    cyc();
    imem_gnt = 1'b1; rsp_en = 1'b0;
    cyc();
    imem_gnt = 1'b0;
    #1;
    check("pre_rst_valid", 32'(out_valid), 1);
    check("pre_rst_req",   32'(imem_req),  1);
    #1;
    reset = 1'b0;
    #1;
    check("ar_req",   32'(imem_req),  0);
    check("ar_addr",  32'(imem_addr), 0);
    check("ar_valid", 32'(out_valid), 0);
    check("ar_pc",    32'(out_pc),    0);
    check("ar_instr", out_instr,      0);
    check("ar_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1; rsp_en = 1'b1; out_ready = 1'b1;
    cyc();
    check("late_rvalid", 32'(s_rvalid), 1);
    run(3);
    check("late_valid", 32'(s_valid), 0);
    check("late_count", 32'(dut.count), 0);
    check("late_outst", 32'(dut.outstanding), 0);
    clear_logs();
    imem_gnt = 1'b1;
    run(3);
    check("restart_cnt", 32'(glog.size() >= 2), 1);
    check("restart_addr0", 32'(glog[0]), 0);
    check("restart_addr1", 32'(glog[1]), 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
